// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared fetch-unit constants, next-PC encodings and state enum
package ifu_pkg;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam int          IM_WORDS = 1024;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/ifu_pc_if.sv
// rtl/ifu_pc_if.sv - next-PC request/result bundle between the PC controller and npc
interface ifu_pc_if;

  logic [31:0] pc;
  logic [1:0]  npc_sel;
  logic        br_taken;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] jr_target;
  logic        stall;
  logic [31:0] next_pc;
  logic        addr_err;

  modport master (
    output pc, npc_sel, br_taken, imm16, instr_index, jr_target, stall,
    input  next_pc, addr_err
  );

  modport slave (
    input  pc, npc_sel, br_taken, imm16, instr_index, jr_target, stall,
    output next_pc, addr_err
  );

endinterface

// File: rtl/npc.sv
// rtl/npc.sv - combinational next-PC selection and address range/alignment check
module npc
  import ifu_pkg::*;
#(
  parameter logic [31:0] PC_RESET = ifu_pkg::PC_RESET,
  parameter int          IM_WORDS = ifu_pkg::IM_WORDS
) (
  ifu_pc_if.slave bus
);

  localparam logic [31:0] PC_LAST = PC_RESET + 32'(IM_WORDS * 4) - 32'd4;

  logic [31:0] seq_pc;
  logic [31:0] br_off;
  logic [31:0] cand;

  always_comb begin
    seq_pc = bus.pc + 32'd4;
    br_off = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
    cand   = seq_pc;
    case (bus.npc_sel)
      NPC_SEQ: cand = seq_pc;
      NPC_BR:  cand = bus.br_taken ? (seq_pc + br_off) : seq_pc;
      NPC_J:   cand = {seq_pc[31:28], bus.instr_index, 2'b00};
      default: cand = bus.jr_target;
    endcase
  end

  // Running off the last word is just another out-of-range candidate: no wrap.
  assign bus.next_pc  = cand;
  assign bus.addr_err = (cand[1:0] != 2'b00) || (cand < PC_RESET) || (cand > PC_LAST);

endmodule

// File: rtl/ifu_pc.sv
// rtl/ifu_pc.sv - program counter register, boot/run/fault FSM and fetch enables
module ifu_pc
  import ifu_pkg::*;
#(
  parameter logic [31:0] PC_RESET = ifu_pkg::PC_RESET,
  parameter int          IM_WORDS = ifu_pkg::IM_WORDS,
  localparam int         AW       = $clog2(IM_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic [1:0]    npc_sel,
  input  logic          br_taken,
  input  logic [15:0]   imm16,
  input  logic [25:0]   instr_index,
  input  logic [31:0]   jr_target,
  output logic [31:0]   pc,
  output logic [31:0]   pc_plus4,
  output logic [AW-1:0] im_addr,
  output logic          im_enable,
  output logic          fetch_valid,
  output logic          fault
);

  localparam logic [1:0] BOOT  = ST_BOOT;
  localparam logic [1:0] RUN   = ST_RUN;
  localparam logic [1:0] FAULT = ST_FAULT;

  logic [1:0]  state;
  logic [31:0] pc_q;
  logic        fault_q;

  ifu_pc_if u_bus ();

  assign u_bus.pc          = pc_q;
  assign u_bus.npc_sel     = npc_sel;
  assign u_bus.br_taken    = br_taken;
  assign u_bus.imm16       = imm16;
  assign u_bus.instr_index = instr_index;
  assign u_bus.jr_target   = jr_target;
  assign u_bus.stall       = stall;

  npc #(
    .PC_RESET (PC_RESET),
    .IM_WORDS (IM_WORDS)
  ) u_npc (
    .bus (u_bus)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= PC_RESET;
      state   <= BOOT;
      fault_q <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          // A stalled cycle never evaluates the candidate, so it cannot fault.
          if (!stall) begin
            if (u_bus.addr_err) begin
              state   <= FAULT;
              fault_q <= 1'b1;
            end else begin
              pc_q <= u_bus.next_pc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign im_addr     = AW'((pc_q - PC_RESET) >> 2);
  assign im_enable   = (state == RUN);
  assign fetch_valid = (state == RUN) && !stall;
  assign fault       = fault_q;

endmodule

// File: tb/tb_ifu_pc.sv
// tb/tb_ifu_pc.sv - scoreboard bench for ifu_pc with directed and random next-PC traffic
module tb_ifu_pc;

  localparam logic [31:0] PCR   = 32'h0000_3000;
  localparam int          WORDS = 1024;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [9:0]  ia;
    logic        ime;
    logic        fv;
    logic        flt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_plus4;
  logic [9:0]  im_addr;
  logic        im_enable, fetch_valid, fault;

  ifu_pc_if bus ();

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: 0 = booting, 1 = running, 2 = faulted
  logic [31:0] m_pc = PCR;
  int          m_st = 0;
  bit          m_flt = 1'b0;
  bit          known = 1'b0;

  always #5 clk = ~clk;

  ifu_pc dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (bus.stall),
    .npc_sel     (bus.npc_sel),
    .br_taken    (bus.br_taken),
    .imm16       (bus.imm16),
    .instr_index (bus.instr_index),
    .jr_target   (bus.jr_target),
    .pc          (bus.pc),
    .pc_plus4    (pc_plus4),
    .im_addr     (im_addr),
    .im_enable   (im_enable),
    .fetch_valid (fetch_valid),
    .fault       (fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pc",          bus.pc,              e.pc);
      chk("pc_plus4",    pc_plus4,            e.pc4);
      chk("im_addr",     32'(im_addr),        32'(e.ia));
      chk("im_enable",   32'(im_enable),      32'(e.ime));
      chk("fetch_valid", 32'(fetch_valid),    32'(e.fv));
      chk("fault",       32'(fault),          32'(e.flt));
    end
  end

  function automatic bit in_range(input logic [31:0] a);
    return (a % 4 == 0) && (a >= PCR) && (a <= PCR + 4 * WORDS - 4);
  endfunction

  task automatic step(input bit r, input bit st, input logic [1:0] sel, input bit bt,
                      input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] jr);
    logic [31:0] tgt;
    exp_t e;
    @(posedge clk);
    #1;
    rst_n           = r;
    bus.stall       = st;
    bus.npc_sel     = sel;
    bus.br_taken    = bt;
    bus.imm16       = imm;
    bus.instr_index = idx;
    bus.jr_target   = jr;
    if (known) begin
      e.pc  = m_pc;
      e.pc4 = m_pc + 4;
      e.ia  = 10'((m_pc - PCR) / 4);
      e.ime = (m_st == 1);
      e.fv  = (m_st == 1) && !st;
      e.flt = m_flt;
      sb.push_back(e);
    end
    if (!r) begin
      m_pc = PCR; m_st = 0; m_flt = 1'b0; known = 1'b1;
    end else if (m_st == 0) begin
      m_st = 1;
    end else if (m_st == 1 && !st) begin
      case (sel)
        2'd0:    tgt = m_pc + 4;
        2'd1:    tgt = bt ? m_pc + 4 + 32'($signed(imm) * 4) : m_pc + 4;
        2'd2:    tgt = ((m_pc + 4) & 32'hF000_0000) | (32'(idx) * 4);
        default: tgt = jr;
      endcase
      if (in_range(tgt)) m_pc = tgt;
      else begin m_st = 2; m_flt = 1'b1; end
    end
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
  endtask

  task automatic do_reset(input bit st);
    step(0, st, 2'd0, 0, 16'h0, 26'h0, 32'h0);
  endtask

  initial begin
    bus.stall = 1'b0; bus.npc_sel = 2'd0; bus.br_taken = 1'b0;
    bus.imm16 = 16'h0; bus.instr_index = 26'h0; bus.jr_target = 32'h0;

    do_reset(0); do_reset(0);
    seq(5);                                               // boot, then 3000..3010
    step(1, 0, 2'd1, 1, 16'hFFFC, 26'h0, 32'h0);          // 3010 -> 3004
    seq(3);                                               // back to 3010
    step(1, 0, 2'd1, 0, 16'hFFFC, 26'h0, 32'h0);          // not taken -> 3014
    step(1, 0, 2'd3, 0, 16'h0, 26'h0, 32'h3008);          // jr to 3008
    step(1, 0, 2'd2, 0, 16'h0, 26'h0000C10, 32'h0);       // j -> 3040
    for (int i = 0; i < 3; i++) step(1, 1, 2'd3, 0, 16'h0, 26'h0, 32'h3002);
    step(1, 0, 2'd3, 0, 16'h0, 26'h0, 32'h3002);          // misaligned -> fault
    step(1, 0, 2'd3, 0, 16'h0, 26'h0, 32'h3100);
    step(1, 0, 2'd3, 0, 16'h0, 26'h0, 32'h3100);
    do_reset(1);                                          // reset out of FAULT with stall
    seq(1 + 1023);                                        // boot, then up to 3FFC
    seq(3);                                               // past the end -> fault, held
    do_reset(1);
    seq(2);

    for (int i = 0; i < 1500; i++) begin
      bit          r, st, bt;
      logic [1:0]  sel;
      logic [15:0] imm;
      logic [25:0] idx;
      logic [31:0] jr;
      r   = !((m_st == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 60) == 0);
      st  = ($urandom_range(0, 3) == 0);
      sel = 2'($urandom_range(0, 3));
      bt  = 1'($urandom_range(0, 1));
      imm = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 64) - 32);
      idx = 26'($urandom_range(32'h0BF8, 32'h1008));
      jr  = PCR + 32'($urandom_range(0, 32'h1010));
      if ($urandom_range(0, 1) == 1) jr[1:0] = 2'b00;
      step(r, st, sel, bt, imm, idx, jr);
    end

    begin
      int waited = 0;
      while (sb.size() > 0 && waited < 20) begin
        @(posedge clk);
        waited++;
      end
      if (sb.size() > 0) begin
        bad++;
        $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifu_pc.md
IFU_PC -- requirements
Module: ifu_pc

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_3000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter IM_WORDS, default 1024, meaning the instruction-memory depth in 32-bit words.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port stall  input  1  hold the PC this cycle.
REQ-006 SHALL have port npc_sel  input  2  next-PC select: 00 sequential, 01 branch, 10 jump, 11 register jump.
REQ-007 SHALL have port br_taken  input  1  branch condition; meaningful only when npc_sel=01.
REQ-008 SHALL have port imm16  input  16  branch offset in words, signed.
REQ-009 SHALL have port instr_index  input  26  jump target field.
REQ-010 SHALL have port jr_target  input  32  register-jump target byte address.
REQ-011 SHALL have port pc  output  32  current fetch address.
REQ-012 SHALL have port pc_plus4  output  32  pc+4, used for link and for jump targets.
REQ-013 SHALL have port im_addr  output  log2(IM_WORDS)  word index into instruction memory, i.e. (pc-PC_RESET)>>2.
REQ-014 SHALL have port im_enable  output  1  instruction-memory read enable.
REQ-015 SHALL have port fetch_valid  output  1  the word returned by instruction memory this cycle is a real instruction.
REQ-016 SHALL have port fault  output  1  sticky address-error flag.

Function
REQ-017 SHALL implement the FSM states BOOT, RUN and FAULT.
REQ-018 BOOT SHALL last exactly one cycle after reset release, with im_enable=0 and fetch_valid=0, then go to RUN.
REQ-019 In RUN, im_enable SHALL be 1 and fetch_valid SHALL be !stall.
REQ-020 In RUN with stall=1, pc SHALL hold regardless of npc_sel, and fault SHALL NOT be evaluated.
REQ-021 In RUN with stall=0, pc SHALL load next_pc on the clock edge.
REQ-022 next_pc SHALL be selected as follows:
- 00: pc+4
- 01: br_taken ? pc+4+(sext(imm16)<<2) : pc+4
- 10: {pc_plus4[31:28], instr_index, 2'b00}
- 11: jr_target
REQ-023 All address arithmetic SHALL be 32-bit modulo 2^32; carry out SHALL be discarded.
REQ-024 A candidate next_pc with next_pc[1:0]!=0, or outside [PC_RESET, PC_RESET+4*IM_WORDS-4], SHALL NOT be loaded.
- pc SHALL hold, fault SHALL be set, and the FSM SHALL go to FAULT on that edge.
REQ-025 Sequential fetch past the last word SHALL trigger the same fault as REQ-024; there is no wrap-around.
REQ-026 FAULT SHALL be absorbing until reset, with im_enable=0, fetch_valid=0, fault=1 and pc frozen.
REQ-027 pc_plus4 and im_addr SHALL be combinational from the pc register, with zero latency.

Reset
REQ-028 When rst_n=0 at a rising edge, the block SHALL set pc=PC_RESET, state=BOOT and fault=0, overriding stall and any fault, including mid-operation.
REQ-029 During reset and BOOT, im_enable=0, fetch_valid=0, im_addr=0 and pc_plus4=PC_RESET+4.

Structure
REQ-030 A shared package ifu_pkg SHALL hold the following, for reuse by im, the decoder and the controller:
- npc_sel encodings NPC_SEQ, NPC_BR, NPC_J and NPC_JR
- the state enum
- PC_RESET
- IM_WORDS
REQ-031 Next-PC calculation SHALL be a separate combinational sub-module npc.
- It SHALL take inputs pc, npc_sel, br_taken, imm16, instr_index and jr_target.
- It SHALL produce outputs next_pc and addr_err.
- ifu_pc SHALL hold the register, the FSM and the enable logic.

Verification
REQ-032 Bench SHALL apply reset, release, then 4 run cycles with npc_sel=00 -> BOOT cycle with im_enable=0; then pc 3000, 3004, 3008, 300C with fetch_valid=1.
REQ-033 Bench SHALL apply pc=3010, npc_sel=01, br_taken=1, imm16=16'hFFFC -> next pc=3004; with br_taken=0 -> next pc=3014.
REQ-034 Bench SHALL apply pc=3008, npc_sel=10, instr_index=26'h0000C10 -> next pc=3040; then stall=1 for 3 cycles -> pc stays 3040, fetch_valid=0, no fault.
REQ-035 Bench SHALL apply npc_sel=11, jr_target=3002 -> fault=1, pc held, im_enable=0; then jr_target=3100 -> no change while faulted.
REQ-036 Bench SHALL drive sequential fetch to pc=3FFC, then one more unstalled cycle -> fault=1, pc=3FFC.
REQ-037 Bench SHALL assert rst_n=0 while in FAULT and while stall=1 -> next edge pc=3000, fault=0, state BOOT.
